// File: rtl/gfx_pkg.sv
// gfx_pkg: shared flow tag type and datapath pipeline-depth constants for the gfx block.
// Depths derive from the build macros `FP_INV_STAGES and `FP_MUL_STAGES; defaults apply when
// the build does not set them. Blocks instantiating gfx_tagged_pipeline_flow take STAGES and
// TAP_STAGE from the *_DEPTH / *_TAP constants below.
`ifndef FP_INV_STAGES
`define FP_INV_STAGES 4
`endif
`ifndef FP_MUL_STAGES
`define FP_MUL_STAGES 3
`endif
package gfx_pkg;
    localparam int FLOW_TAG_W = 1;
    typedef logic [FLOW_TAG_W-1:0] flow_tag_t;
    localparam int FP_INV_DEPTH = `FP_INV_STAGES;
    localparam int FP_INV_TAP = FP_INV_DEPTH / 2;
    localparam int FP_MUL_DEPTH = `FP_MUL_STAGES;
    localparam int FP_MUL_TAP = FP_MUL_DEPTH / 2;
    // perspective divide = reciprocal followed by multiply; tap at the reciprocal result
    localparam int PERSP_DIV_DEPTH = FP_INV_DEPTH + FP_MUL_DEPTH;
    localparam int PERSP_DIV_TAP = FP_INV_DEPTH - 1;
endpackage

// File: rtl/gfx_flow_stage.sv
// gfx_flow_stage: one pipeline slot holding a valid bit and sideband tag.
// Ports: clk, rst_n (async, active-low); en loads the slot from src_valid/src_tag,
// otherwise it holds; valid/tag are the registered slot contents. An invalid slot
// always carries tag 0.
import gfx_pkg::*;

module gfx_flow_stage #(
    parameter int TAG_WIDTH = FLOW_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 src_valid,
    input  logic [TAG_WIDTH-1:0] src_tag,
    output logic                 valid,
    output logic [TAG_WIDTH-1:0] tag
);
    logic                 valid_q, valid_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;

    always_comb begin
        valid_d = en ? src_valid : valid_q;
        tag_d   = en ? (src_valid ? src_tag : '0) : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign valid = valid_q;
    assign tag   = tag_q;
endmodule

// File: rtl/gfx_tagged_pipeline_flow.sv
// gfx_tagged_pipeline_flow: valid/ready flow controller with per-slot tags for stall-able
// datapath pipelines. Drives the external datapath register enables (stage_en / stall).
// Ports: clk, rst_n (async, active-low); upstream in_valid/in_ready/in_tag; downstream
// out_valid/out_ready/out_tag; stage_en per slot, stall = ~stage_en[STAGES-1];
// tap_valid/tap_tag observe slot TAP_STAGE; occupancy counts valid slots.
// Build macro GFX_FLOW_BUBBLE_COLLAPSE_EN: per-slot enables that let bubbles be squeezed
// out behind a stalled output; undefined gives one lockstep global stall.
import gfx_pkg::*;

module gfx_tagged_pipeline_flow #(
    parameter int STAGES    = 4,
    parameter int TAG_WIDTH = FLOW_TAG_W,
    parameter int TAP_STAGE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [TAG_WIDTH-1:0]         in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TAG_WIDTH-1:0]         out_tag,
    output logic [STAGES-1:0]            stage_en,
    output logic                         stall,
    output logic                         tap_valid,
    output logic [TAG_WIDTH-1:0]         tap_tag,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);
    localparam int OW = $clog2(STAGES + 1);

    logic [STAGES-1:0]    valid;
    logic [TAG_WIDTH-1:0] tag [STAGES];
    logic [STAGES-1:0]    src_valid;
    logic [TAG_WIDTH-1:0] src_tag [STAGES];
    logic                 in_xfer, out_xfer;
    logic [OW-1:0]        occ_q, occ_d;

    always_comb begin
        src_valid[0] = in_valid;
        src_tag[0]   = in_tag;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = valid[i-1];
            src_tag[i]   = tag[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        gfx_flow_stage #(.TAG_WIDTH(TAG_WIDTH)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (stage_en[g]),
            .src_valid (src_valid[g]),
            .src_tag   (src_tag[g]),
            .valid     (valid[g]),
            .tag       (tag[g])
        );
    end

`ifdef GFX_FLOW_BUBBLE_COLLAPSE_EN
    // A slot may advance if it is empty or everything downstream of it advances;
    // accumulated from the output end so no signal feeds back on itself.
    logic move;
    always_comb begin
        stage_en = '0;
        move     = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            move        = move || !valid[i];
            stage_en[i] = move;
        end
    end
`else
    assign stage_en = {STAGES{!(valid[STAGES-1] && !out_ready)}};
`endif

    assign stall     = !stage_en[STAGES-1];
    assign in_ready  = stage_en[0];
    assign out_valid = valid[STAGES-1];
    assign out_tag   = tag[STAGES-1];
    assign tap_valid = valid[TAP_STAGE];
    assign tap_tag   = tag[TAP_STAGE];

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid[STAGES-1] && out_ready;

    always_comb occ_d = occ_q + OW'(in_xfer) - OW'(out_xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    assign occupancy = occ_q;
endmodule

// File: tb/tb_gfx_tagged_pipeline_flow.sv
// tb_gfx_tagged_pipeline_flow: self-checking bench for gfx_tagged_pipeline_flow
// (STAGES=4/TAP_STAGE=1 and STAGES=1 instances, TAG_WIDTH=8).
module tb_gfx_tagged_pipeline_flow;
`ifdef GFX_FLOW_BUBBLE_COLLAPSE_EN
    localparam bit COLLAPSE = 1'b1;
`else
    localparam bit COLLAPSE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_tag = 8'h00;
    logic       in_ready, out_valid, stall, tap_valid;
    logic [7:0] out_tag, tap_tag;
    logic [3:0] stage_en;
    logic [2:0] occupancy;

    logic       b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [7:0] b_in_tag = 8'h00;
    logic       b_in_ready, b_out_valid, b_stall, b_tap_valid;
    logic [7:0] b_out_tag, b_tap_tag;
    logic [0:0] b_stage_en;
    logic [0:0] b_occupancy;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    gfx_tagged_pipeline_flow #(.STAGES(4), .TAG_WIDTH(8), .TAP_STAGE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .stage_en(stage_en),
        .stall(stall), .tap_valid(tap_valid), .tap_tag(tap_tag), .occupancy(occupancy)
    );

    gfx_tagged_pipeline_flow #(.STAGES(1), .TAG_WIDTH(8), .TAP_STAGE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_tag(b_out_tag), .stage_en(b_stage_en),
        .stall(b_stall), .tap_valid(b_tap_valid), .tap_tag(b_tap_tag), .occupancy(b_occupancy)
    );

    // Scoreboard: expected tags pushed on each input transfer, popped on each output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard: output tag %0h with no item outstanding", out_tag);
                end else begin
                    logic [7:0] exp;
                    exp = sb.pop_front();
                    if (out_tag !== exp) begin
                        failures++;
                        $display("FAIL scoreboard: out_tag got %0h expected %0h", out_tag, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_tag);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, tap_valid, stall, in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_flags: out_valid/tap_valid/stall/in_ready got %b expected 0001",
                     {out_valid, tap_valid, stall, in_ready});
        end
        checks++;
        if ({out_tag, tap_tag} !== 16'h0000 || stage_en !== 4'hF || occupancy !== 3'd0) begin
            failures++;
            $display("FAIL reset_values: tags %h stage_en %b occ %0d expected 0000 1111 0",
                     {out_tag, tap_tag}, stage_en, occupancy);
        end
        checks++;
        if ({b_out_valid, b_in_ready, b_stall, b_stage_en} !== 4'b0101) begin
            failures++;
            $display("FAIL reset_single: out_valid/in_ready/stall/stage_en got %b expected 0101",
                     {b_out_valid, b_in_ready, b_stall, b_stage_en});
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (occupancy !== 3'd0 && n < 20) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain: occupancy %0d out_valid %b expected 0 0", name, occupancy, out_valid);
        end
        next_cycle();
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k == 0);
            in_tag   = 8'd1;
            @(negedge clk);
            checks++;
            if (tap_valid !== (k == 2) || (k == 2 && tap_tag !== 8'd1)) begin
                failures++;
                $display("FAIL latency_tap k=%0d: tap_valid %b tap_tag %0h expected %b 01", k, tap_valid, tap_tag, k == 2);
            end
            checks++;
            if (out_valid !== (k == 4) || (k == 4 && out_tag !== 8'd1)) begin
                failures++;
                $display("FAIL latency_out k=%0d: out_valid %b out_tag %0h expected %b 01", k, out_valid, out_tag, k == 4);
            end
            checks++;
            if (occupancy !== ((k >= 1 && k <= 4) ? 3'd1 : 3'd0)) begin
                failures++;
                $display("FAIL latency_occ k=%0d: occupancy %0d", k, occupancy);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid  = (k <= 4);
            in_tag    = 8'(k + 1);
            out_ready = (k >= 5);
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (in_ready !== 1'b0 || occupancy !== 3'd4 || out_valid !== 1'b1 || out_tag !== 8'd1) begin
                    failures++;
                    $display("FAIL b2b_full: in_ready %b occ %0d out_valid %b out_tag %0h expected 0 4 1 01",
                             in_ready, occupancy, out_valid, out_tag);
                end
            end
            if (k >= 5 && k <= 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_tag !== 8'(k - 4) || occupancy !== 3'(9 - k)) begin
                    failures++;
                    $display("FAIL b2b_drain k=%0d: out_valid %b out_tag %0h occ %0d expected 1 %0h %0d",
                             k, out_valid, out_tag, occupancy, k - 4, 9 - k);
                end
            end
            if (k == 9) begin
                checks++;
                if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
                    failures++;
                    $display("FAIL b2b_empty: out_valid %b occ %0d expected 0 0", out_valid, occupancy);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_bubbles();
        logic [3:0] en_c[8]  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
        logic [3:0] en_n[8]  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [2:0] occ_c[8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
        logic [2:0] occ_n[8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
        logic [7:0] rdy_c    = 8'b0111_1111;
        logic [7:0] rdy_n    = 8'b0000_1111;
        logic [3:0] exp_en;
        logic [2:0] exp_occ;
        logic       exp_rdy;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = (k % 2 == 0);
            in_tag   = 8'(8'h10 + k);
            exp_en   = COLLAPSE ? en_c[k] : en_n[k];
            exp_occ  = COLLAPSE ? occ_c[k] : occ_n[k];
            exp_rdy  = COLLAPSE ? rdy_c[k] : rdy_n[k];
            @(negedge clk);
            checks++;
            if (in_ready !== exp_rdy || stage_en !== exp_en) begin
                failures++;
                $display("FAIL bubbles_en k=%0d: in_ready %b stage_en %b expected %b %b", k, in_ready, stage_en, exp_rdy, exp_en);
            end
            checks++;
            if (occupancy !== exp_occ || stall !== (k >= 4)) begin
                failures++;
                $display("FAIL bubbles_occ k=%0d: occ %0d stall %b expected %0d %b", k, occupancy, stall, exp_occ, k >= 4);
            end
            next_cycle();
        end
        drain("bubbles");
    endtask

    task automatic test_throughput();
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_tag   = 8'(8'h20 + k);
            @(negedge clk);
            if (k >= 4) begin
                checks++;
                if (occupancy !== 3'd4 || out_valid !== 1'b1 || in_ready !== 1'b1 || out_tag !== 8'(8'h20 + k - 4)) begin
                    failures++;
                    $display("FAIL throughput k=%0d: occ %0d out_valid %b in_ready %b out_tag %0h expected 4 1 1 %0h",
                             k, occupancy, out_valid, in_ready, out_tag, 8'h20 + k - 4);
                end
            end
            next_cycle();
        end
        drain("throughput");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = (k < 3);
            in_tag   = 8'(8'h30 + k);
            next_cycle();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, tap_valid, stall, in_ready} !== 4'b0001 || occupancy !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_flags: out_valid/tap_valid/stall/in_ready %b occ %0d expected 0001 0",
                     {out_valid, tap_valid, stall, in_ready}, occupancy);
        end
        checks++;
        if ({out_tag, tap_tag} !== 16'h0000 || stage_en !== 4'hF) begin
            failures++;
            $display("FAIL reset_mid_tags: tags %h stage_en %b expected 0000 1111", {out_tag, tap_tag}, stage_en);
        end
        @(negedge clk);
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k == 0);
            in_tag   = 8'h77;
            @(negedge clk);
            checks++;
            if (out_valid !== (k == 4) || (k == 4 && out_tag !== 8'h77)) begin
                failures++;
                $display("FAIL reset_mid_relaunch k=%0d: out_valid %b out_tag %0h expected %b 77", k, out_valid, out_tag, k == 4);
            end
            next_cycle();
        end
    endtask

    task automatic test_single_stage();
        b_out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            b_in_valid  = (k <= 4);
            b_in_tag    = (k == 0) ? 8'hA5 : 8'h5A;
            b_out_ready = (k >= 4);
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL single_load: in_ready %b out_valid %b expected 1 0", b_in_ready, b_out_valid);
                end
            end
            if (k >= 1 && k <= 3) begin
                checks++;
                if (b_out_valid !== 1'b1 || b_out_tag !== 8'hA5 || b_tap_valid !== 1'b1 || b_tap_tag !== 8'hA5) begin
                    failures++;
                    $display("FAIL single_hold k=%0d: out_valid %b out_tag %0h tap %b %0h expected 1 a5 1 a5",
                             k, b_out_valid, b_out_tag, b_tap_valid, b_tap_tag);
                end
                checks++;
                if (b_in_ready !== 1'b0 || b_stall !== 1'b1 || b_stage_en !== 1'b0 || b_occupancy !== 1'b1) begin
                    failures++;
                    $display("FAIL single_stall k=%0d: in_ready %b stall %b stage_en %b occ %0d expected 0 1 0 1",
                             k, b_in_ready, b_stall, b_stage_en, b_occupancy);
                end
            end
            if (k == 4) begin
                checks++;
                if (b_in_ready !== 1'b1 || b_out_tag !== 8'hA5) begin
                    failures++;
                    $display("FAIL single_release: in_ready %b out_tag %0h expected 1 a5", b_in_ready, b_out_tag);
                end
            end
            if (k == 5) begin
                checks++;
                if (b_out_valid !== 1'b1 || b_out_tag !== 8'h5A || b_occupancy !== 1'b1) begin
                    failures++;
                    $display("FAIL single_next: out_valid %b out_tag %0h occ %0d expected 1 5a 1", b_out_valid, b_out_tag, b_occupancy);
                end
            end
            if (k == 6) begin
                checks++;
                if (b_out_valid !== 1'b0 || b_out_tag !== 8'h00 || b_occupancy !== 1'b0) begin
                    failures++;
                    $display("FAIL single_empty: out_valid %b out_tag %0h occ %0d expected 0 00 0", b_out_valid, b_out_tag, b_occupancy);
                end
            end
            next_cycle();
        end
        b_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_bubbles();
        test_throughput();
        test_reset_mid();
        test_single_stage();
        drain("final");
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: %0d items outstanding, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
